// File: rtl/bsg_fifo_1r1w_rolly_gen.sv
// rtl/bsg_fifo_1r1w_rolly_gen.sv - rollback FIFO with write, speculative-read and commit pointers
module bsg_fifo_1r1w_rolly_gen #(
  parameter int width_p      = 32,
  parameter int els_p        = 8,
  parameter int commit_max_p = 2,
  localparam int lg_els_lp       = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int cnt_width_lp    = (els_p + 1 > 1) ? $clog2(els_p + 1) : 1,
  localparam int commit_width_lp = (commit_max_p + 1 > 1) ? $clog2(commit_max_p + 1) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [width_p-1:0]         data_o,
  output logic                       v_o,
  input  logic                       yumi_i,
  input  logic [commit_width_lp-1:0] commit_cnt_i,
  input  logic                       roll_i,
  input  logic                       clr_i,
  output logic [cnt_width_lp-1:0]    occupancy_o,
  output logic [cnt_width_lp-1:0]    unread_o
);

  typedef struct packed {
    logic                 wrap;
    logic [lg_els_lp-1:0] idx;
  } ptr_t;

  localparam logic [cnt_width_lp:0]   els_ext_lp = (cnt_width_lp+1)'(els_p);
  localparam logic [cnt_width_lp-1:0] els_cnt_lp = cnt_width_lp'(els_p);

  // Increment never exceeds els_p, so at most one wrap toggle per add.
  function automatic ptr_t ptr_add(ptr_t p, logic [cnt_width_lp-1:0] inc);
    logic [cnt_width_lp:0] sum;
    ptr_t r;
    sum = (cnt_width_lp+1)'(p.idx) + {1'b0, inc};
    if (sum >= els_ext_lp) begin
      r.idx  = lg_els_lp'(sum - els_ext_lp);
      r.wrap = ~p.wrap;
    end else begin
      r.idx  = lg_els_lp'(sum);
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  function automatic logic [cnt_width_lp-1:0] ptr_diff(ptr_t a, ptr_t b);
    logic [cnt_width_lp-1:0] ai, bi;
    ai = cnt_width_lp'(a.idx);
    bi = cnt_width_lp'(b.idx);
    return (a.wrap == b.wrap) ? (ai - bi) : (ai + els_cnt_lp - bi);
  endfunction

  ptr_t wptr_r, rptr_r, cptr_r;
  ptr_t wptr_n, rptr_n, cptr_n;
  logic [width_p-1:0] mem [els_p];

  logic [cnt_width_lp-1:0] held_cnt, unread_cnt, spec_cnt;
  logic full, empty, enq, rd;

  assign held_cnt   = ptr_diff(wptr_r, cptr_r);
  assign unread_cnt = ptr_diff(wptr_r, rptr_r);
  assign spec_cnt   = ptr_diff(rptr_r, cptr_r);

  assign full  = (held_cnt == els_cnt_lp);
  assign empty = (rptr_r == wptr_r);

  assign ready_o = reset_n_i & ~clr_i & ~full;
  assign v_o     = reset_n_i & ~roll_i & ~empty;
  assign enq     = v_i & ready_o;
  assign rd      = yumi_i & v_o;

  assign occupancy_o = reset_n_i ? held_cnt   : '0;
  assign unread_o    = reset_n_i ? unread_cnt : '0;

  // Commit lands first; roll then rewinds to the freshly committed point.
  assign cptr_n = ptr_add(cptr_r, cnt_width_lp'(commit_cnt_i));
  assign rptr_n = roll_i ? cptr_n : ptr_add(rptr_r, cnt_width_lp'(rd));
  assign wptr_n = clr_i  ? rptr_n : ptr_add(wptr_r, cnt_width_lp'(enq));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_r.idx] <= data_i;
  end

  assign data_o = mem[rptr_r.idx];

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (cnt_width_lp'(commit_cnt_i) <= spec_cnt);
      assert (!yumi_i || v_o);
      assert (commit_cnt_i <= commit_width_lp'(commit_max_p));
    end
  end

endmodule
